// File: rtl/uart_rx_fifo_if.sv
// Receive-side FWFT FIFO between UART_RX and the Crypter.
// Tracks queued EOT words and flags dropped pushes (overrun).
module uart_rx_fifo_if #(
  parameter int unsigned         DATA_W   = 8,
  parameter int unsigned         DEPTH    = 16,
  parameter logic [DATA_W-1:0]   EOT_CHAR = DATA_W'(4),
  parameter bit                  EOT_EN   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_flag,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     clear_flag,
  input  logic                     overrun_clr,
  output logic                     flag,
  output logic [DATA_W-1:0]        data_out,
  output logic                     eot,
  output logic                     eot_pending,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     eot_cnt;
  logic [CW-1:0]     count_nxt;
  logic [CW-1:0]     eot_cnt_nxt;
  logic [DATA_W-1:0] head;
  logic              pop_ok;
  logic              push;
  logic              drop;
  logic              push_eot;
  logic              pop_eot;

  assign head     = mem[rd_ptr];
  assign flag     = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = clear_flag && flag;
  assign push     = set_flag && (!full || pop_ok);
  assign drop     = set_flag && full && !pop_ok;
  assign push_eot = EOT_EN && push && (data_in == EOT_CHAR);
  assign pop_eot  = EOT_EN && pop_ok && (head == EOT_CHAR);

  // Stale memory is masked whenever the FIFO is empty
  assign data_out    = flag ? head : '0;
  assign eot         = EOT_EN && flag && (head == EOT_CHAR);
  assign eot_pending = (eot_cnt != '0);

  // Occupancy and EOT bookkeeping
  always_comb begin
    count_nxt   = count;
    eot_cnt_nxt = eot_cnt;
    if (push && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop_ok) begin
      count_nxt = count - CW'(1);
    end
    if (push_eot && !pop_eot) begin
      eot_cnt_nxt = eot_cnt + CW'(1);
    end else if (!push_eot && pop_eot) begin
      eot_cnt_nxt = eot_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      eot_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      count   <= count_nxt;
      eot_cnt <= eot_cnt_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A dropped push outranks a clear in the same cycle
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule
